psum_binarizer: RTL and testbench
=================================

# psum_binarizer

Downstream stage of the PE-array `top`: consumes the 14-bit partial sums it pops on `sum_out` (one per cycle, channel-major, `OUT_ROW_LENGTH` per output channel), compares each against a per-channel signed threshold (folded batch-norm), and produces one binary activation bit per psum. Bits are packed LSB-first into 9-bit words that match the next layer's `data_in` width, so the output stream can be written straight into the next layer's activation buffer.

## Interface
Parameters:
- `WIDTH`, 14, psum and threshold bit width (two's complement)
- `O_CH`, 64, output channels per frame (threshold entries)
- `OUT_ROW_LENGTH`, 4, psums per channel
- `PACK_W`, 9, bits per packed output word

Ports:
- `clk_in`  input  1  clock, all state on rising edge
- `rst_in`  input  1  asynchronous active-low reset
- `thr_in`  input  WIDTH  threshold value
- `thr_load_in`  input  1  write `thr_in` into threshold entry at load pointer
- `psum_in`  input  WIDTH  psum from `top.sum_out`
- `psum_valid_in`  input  1  `psum_in` valid this cycle (driven from `pop`)
- `act_out`  output  PACK_W  packed activation word
- `act_valid_out`  output  1  `act_out` valid, one-cycle pulse per word
- `act_last_out`  output  1  with `act_valid_out`, final word of frame
- `busy_out`  output  1  frame in progress (psum count ≠ 0 or flush pending)
- `err_out`  output  1  sticky protocol error

## Operation
- Frame = `O_CH*OUT_ROW_LENGTH` psums (default 256). Psum index i → channel c = i / `OUT_ROW_LENGTH`.
- Bit rule: bit = 1 iff `$signed(psum_in) >= $signed(thr[c])`; equality gives 1.
- Threshold load: each `thr_load_in` cycle writes thr[load_ptr], load_ptr increments, wraps `O_CH-1`→0. Thresholds are retained across frames; reloading is optional.
- Packing: bit k of a word is the k-th accepted bit since that word began (first psum → bit 0). After `PACK_W` bits, the word is emitted and the shift register is cleared.
- End of frame: on acceptance of psum index `O_CH*OUT_ROW_LENGTH-1`, the partial word (default 256 mod 9 = 4 bits) is emitted zero-padded in the upper bits with `act_last_out`=1. If the frame size is a multiple of `PACK_W`, the last full word carries `act_last_out`. Words per default frame: 29.
- FSM: IDLE (psum_cnt=0) → RUN on first accepted psum → IDLE on the cycle the last psum is accepted (psum_cnt and bit count wrap to 0). There is no separate flush state; the last word is emitted from the same registered path.
- Simultaneous `thr_load_in` and `psum_valid_in`: threshold write wins, psum is dropped (counters unchanged), `err_out` set.
- `thr_load_in` while `busy_out`=1: the write is performed but `err_out` is set, because the threshold may be read in the same frame.
- `err_out` clears only on reset.

## Timing
- Reset (async, `rst_in`=0): `act_out`=0, `act_valid_out`=0, `act_last_out`=0, `busy_out`=0, `err_out`=0. load_ptr, psum_cnt and bit_cnt are 0; thresholds are 0.
- Reset mid-frame: the partial word is discarded with no output pulse. After release the next psum is index 0.
- Latency: the word containing psum i is presented the cycle after psum i's rising edge (1 cycle, registered output). `act_valid_out` is high for exactly one cycle per word.
- Back-to-back psums every cycle are sustained with no stall. There is no backpressure; the consumer must accept every word.
- Gaps in `psum_valid_in` are allowed; state holds.
- Threshold written at edge t is used by a psum accepted at edge t+1 or later.
- `busy_out` rises the cycle after the first psum is accepted and falls the cycle after the last psum is accepted.

## Test plan
- Reset values: assert `rst_in`=0 mid-clock → all outputs 0 immediately. Release, then send 1 psum, then reset again → no `act_valid_out`; next frame starts at bit 0.
- Threshold compare: thr all 0; psums alternate +1, −1 (14'h3FFF), 0 × 256 → words carry pattern 1,0,1 repeating LSB-first; 29 pulses; last word = 9'b0_0000_xxxx with `act_last_out`=1.
- Per-channel thresholds: thr[c]=c−32; psum = c−32 for all 4 columns → all bits 1. Then psum = c−33 → all bits 0. Word 0 = 9'h1FF then 9'h000 respectively; last word 9'h00F / 9'h000.
- Signed extremes: thr=14'h2000 (−8192) → any psum gives 1. thr=14'h1FFF → only psum 14'h1FFF gives 1.
- Gapped input: psum_valid 1-of-3 cycles for a full frame → identical words to the contiguous case, one-cycle pulses, `busy_out` high throughout.
- Protocol errors: `thr_load_in` and `psum_valid_in` both high → psum dropped (word count stays 29 only after the resend), `err_out`=1 sticky. `thr_load_in` mid-frame → `err_out`=1.

Source files
------------

// File: rtl/psum_binarizer.sv
// Binarizes the PE-array psum stream against per-channel thresholds and packs
// the resulting activation bits LSB-first into words for the next layer.
module psum_binarizer #(
  parameter int WIDTH          = 14,
  parameter int O_CH           = 64,
  parameter int OUT_ROW_LENGTH = 4,
  parameter int PACK_W         = 9
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [WIDTH-1:0]  thr_in,
  input  logic              thr_load_in,
  input  logic [WIDTH-1:0]  psum_in,
  input  logic              psum_valid_in,
  output logic [PACK_W-1:0] act_out,
  output logic              act_valid_out,
  output logic              act_last_out,
  output logic              busy_out,
  output logic              err_out
);

  localparam int CH_W  = (O_CH > 1) ? $clog2(O_CH) : 1;
  localparam int ROW_W = (OUT_ROW_LENGTH > 1) ? $clog2(OUT_ROW_LENGTH) : 1;
  localparam int BIT_W = (PACK_W > 1) ? $clog2(PACK_W) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(O_CH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROW_LENGTH - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PACK_W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  thr_q [O_CH];
  logic signed [WIDTH-1:0]  thr_d [O_CH];
  logic [CH_W-1:0]          ld_ptr_q, ld_ptr_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [PACK_W-1:0]        sr_q, sr_d;
  logic [PACK_W-1:0]        act_q, act_d;
  logic                     act_valid_q, act_valid_d;
  logic                     act_last_q, act_last_d;
  logic                     err_q, err_d;

  logic                     accept;
  logic                     hit;
  logic                     frame_end;
  logic                     word_full;
  logic [PACK_W-1:0]        word;

  // Folded batch-norm: activation fires when psum reaches the channel threshold.
  function automatic logic thr_hit(input logic signed [WIDTH-1:0] p,
                                   input logic signed [WIDTH-1:0] t);
    return p >= t;
  endfunction

  assign accept    = psum_valid_in && !thr_load_in;
  assign hit       = thr_hit($signed(psum_in), thr_q[ch_q]);
  assign frame_end = (ch_q == CH_LAST) && (row_q == ROW_LAST);
  assign word_full = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    ld_ptr_d    = ld_ptr_q;
    ch_d        = ch_q;
    row_d       = row_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    act_d       = act_q;
    act_valid_d = 1'b0;
    act_last_d  = 1'b0;
    err_d       = err_q;
    word        = sr_q;

    // A load races the psum (dropped) or a frame that may read the entry.
    if (thr_load_in) begin
      thr_d[ld_ptr_q] = thr_in;
      ld_ptr_d        = (ld_ptr_q == CH_LAST) ? '0 : ld_ptr_q + 1'b1;
      if (psum_valid_in || (state_q == RUN)) err_d = 1'b1;
    end

    if (accept) begin
      word[bit_cnt_q] = hit;
      if (word_full || frame_end) begin
        act_d       = word;
        act_valid_d = 1'b1;
        act_last_d  = frame_end;
        sr_d        = '0;
        bit_cnt_d   = '0;
      end else begin
        sr_d      = word;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end

      if (row_q == ROW_LAST) begin
        row_d = '0;
        ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end

      state_d = frame_end ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      for (int i = 0; i < O_CH; i++) thr_q[i] <= '0;
      ld_ptr_q    <= '0;
      ch_q        <= '0;
      row_q       <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      act_q       <= '0;
      act_valid_q <= 1'b0;
      act_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      ld_ptr_q    <= ld_ptr_d;
      ch_q        <= ch_d;
      row_q       <= row_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      act_q       <= act_d;
      act_valid_q <= act_valid_d;
      act_last_q  <= act_last_d;
      err_q       <= err_d;
    end
  end

  assign act_out       = act_q;
  assign act_valid_out = act_valid_q;
  assign act_last_out  = act_last_q;
  assign busy_out      = (state_q == RUN);
  assign err_out       = err_q;

endmodule

// File: tb/tb_psum_binarizer.sv
// Scoreboard bench for psum_binarizer: a reference packer queues expected words
// as psums are driven; a negedge monitor pops and compares each emitted word.
module tb_psum_binarizer;

  localparam int WIDTH  = 14;
  localparam int O_CH   = 64;
  localparam int ORL    = 4;
  localparam int PACK_W = 9;
  localparam int FRAME  = O_CH * ORL;

  typedef struct {
    logic [PACK_W-1:0] w;
    logic              last;
    int                cyc;
  } exp_t;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic [WIDTH-1:0]  thr_in = '0;
  logic              thr_load_in = 1'b0;
  logic [WIDTH-1:0]  psum_in = '0;
  logic              psum_valid_in = 1'b0;
  logic [PACK_W-1:0] act_out;
  logic              act_valid_out;
  logic              act_last_out;
  logic              busy_out;
  logic              err_out;

  psum_binarizer #(
    .WIDTH(WIDTH), .O_CH(O_CH), .OUT_ROW_LENGTH(ORL), .PACK_W(PACK_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .thr_in(thr_in), .thr_load_in(thr_load_in),
    .psum_in(psum_in), .psum_valid_in(psum_valid_in), .act_out(act_out),
    .act_valid_out(act_valid_out), .act_last_out(act_last_out),
    .busy_out(busy_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state
  logic signed [WIDTH-1:0] m_thr [O_CH];
  int                      m_ptr, m_idx, m_bc;
  logic [PACK_W-1:0]       m_sr;
  logic                    m_err;
  logic                    exp_busy = 1'b0;
  logic                    exp_err  = 1'b0;
  exp_t                    sbq [$];

  logic [PACK_W-1:0] words [1024];
  logic              lasts [1024];
  int                n_words = 0;
  int                base;

  always @(negedge clk_in) begin
    if (rst_in) begin
      check("busy", busy_out, exp_busy);
      check("err", err_out, exp_err);
      if (act_valid_out) begin
        if (sbq.size() == 0) begin
          check("spurious_valid", act_valid_out, 1'b0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("word", act_out, e.w);
          check("last", act_last_out, e.last);
          check("latency", cyc, e.cyc);
        end
        if (n_words < 1024) begin
          words[n_words] = act_out;
          lasts[n_words] = act_last_out;
        end
        n_words++;
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
    exp_busy = (m_idx != 0);
    exp_err  = m_err;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic model_reset();
    foreach (m_thr[i]) m_thr[i] = '0;
    m_ptr = 0; m_idx = 0; m_bc = 0; m_sr = '0; m_err = 1'b0;
    sbq.delete();
    exp_busy = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] p);
    int   c;
    logic lst;
    exp_t e;
    psum_in = p;
    psum_valid_in = 1'b1;
    c = m_idx / ORL;
    m_sr[m_bc] = ($signed(p) >= m_thr[c]);
    m_bc++;
    lst = (m_idx == FRAME - 1);
    if (m_bc == PACK_W || lst) begin
      e.w = m_sr; e.last = lst; e.cyc = cyc + 1;
      sbq.push_back(e);
      m_sr = '0;
      m_bc = 0;
    end
    m_idx = lst ? 0 : m_idx + 1;
    step();
    psum_valid_in = 1'b0;
  endtask

  task automatic load_thr(input logic [WIDTH-1:0] v);
    thr_load_in = 1'b1;
    thr_in = v;
    if (m_idx != 0) m_err = 1'b1;
    m_thr[m_ptr] = v;
    m_ptr = (m_ptr + 1) % O_CH;
    step();
    thr_load_in = 1'b0;
  endtask

  task automatic collide(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] p);
    thr_load_in = 1'b1;
    psum_valid_in = 1'b1;
    thr_in = v;
    psum_in = p;
    m_err = 1'b1;
    m_thr[m_ptr] = v;
    m_ptr = (m_ptr + 1) % O_CH;
    step();
    thr_load_in = 1'b0;
    psum_valid_in = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] alt_psum(input int i);
    case (i % 3)
      0:       return 14'h0001;
      1:       return 14'h3FFF;
      default: return 14'h0000;
    endcase
  endfunction

  task automatic alt_frame(input int gap);
    base = n_words;
    for (int i = 0; i < FRAME; i++) begin
      send(alt_psum(i));
      idle(gap);
    end
    idle(2);
  endtask

  task automatic check_frame(input string tag, input logic [PACK_W-1:0] w0,
                             input logic [PACK_W-1:0] wl);
    check({tag, "_count"}, n_words - base, 29);
    check({tag, "_w0"}, words[base], w0);
    check({tag, "_wlast"}, words[base + 28], wl);
    check({tag, "_lastflag"}, lasts[base + 28], 1'b1);
    check({tag, "_notlast"}, lasts[base + 27], 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    model_reset();
    #1;
    check("rst_act", act_out, '0);
    check("rst_valid", act_valid_out, 1'b0);
    check("rst_last", act_last_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_err", err_out, 1'b0);
    idle(2);
    rst_in = 1'b1;
    step();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check("init_act", act_out, '0);
    check("init_valid", act_valid_out, 1'b0);
    check("init_last", act_last_out, 1'b0);
    check("init_busy", busy_out, 1'b0);
    check("init_err", err_out, 1'b0);
    rst_in = 1'b1;
    step();

    // Contiguous alternating frame against zero thresholds
    alt_frame(0);
    check_frame("alt", 9'h16D, 9'h00D);

    // Mid-frame collision then async reset discards the partial word
    for (int i = 0; i < 3; i++) send(alt_psum(i));
    collide('0, 14'h0005);
    check("collide_err", err_out, 1'b1);
    check("collide_busy", busy_out, 1'b1);
    async_reset();

    // Gapped frame restarts at bit 0 and matches the contiguous words
    alt_frame(2);
    check_frame("gap", 9'h16D, 9'h00D);

    // Per-channel thresholds c-32
    for (int c = 0; c < O_CH; c++) load_thr(WIDTH'(c - 32));
    base = n_words;
    for (int i = 0; i < FRAME; i++) send(WIDTH'(i / ORL - 32));
    idle(2);
    check_frame("chan_eq", 9'h1FF, 9'h00F);
    base = n_words;
    for (int i = 0; i < FRAME; i++) send(WIDTH'(i / ORL - 33));
    idle(2);
    check_frame("chan_below", 9'h000, 9'h000);

    // Most negative threshold: everything fires
    for (int c = 0; c < O_CH; c++) load_thr(14'h2000);
    base = n_words;
    for (int i = 0; i < FRAME; i++)
      send(i == 0 ? 14'h2000 : (i == 1 ? 14'h1FFF : WIDTH'($urandom_range(0, 16383))));
    idle(2);
    check_frame("thr_min", 9'h1FF, 9'h00F);

    // Most positive threshold: only the maximum psum fires
    for (int c = 0; c < O_CH; c++) load_thr(14'h1FFF);
    base = n_words;
    for (int i = 0; i < FRAME; i++)
      send(i == 0 ? 14'h1FFF : (i == 1 ? 14'h2000 : WIDTH'($urandom_range(0, 8190))));
    idle(2);
    check_frame("thr_max", 9'h001, 9'h000);
    check("thr_max_w1", words[base + 1], 9'h000);
    check("err_clean", err_out, 1'b0);

    // Collision drops the psum; resending it keeps the frame intact
    for (int c = 0; c < O_CH; c++) load_thr('0);
    base = n_words;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 10) collide('0, alt_psum(i));
      send(alt_psum(i));
    end
    idle(2);
    check_frame("drop", 9'h16D, 9'h00D);
    check("drop_err_sticky", err_out, 1'b1);

    // Threshold load while busy flags an error
    async_reset();
    base = n_words;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 10) begin
        load_thr('0);
        check("midload_err", err_out, 1'b1);
      end
      send(alt_psum(i));
    end
    idle(2);
    check_frame("midload", 9'h16D, 9'h00D);
    check("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
